// File: rtl/bitstream_ram_loader.sv
// Purpose : DMA the coded bitstream from external memory into on-chip RAM; serve 16-bit decoder reads.
// Latency : first request the cycle after load_start; load_done the cycle after the final response; reads 1 cycle.
// Backpres: requests stall on mem_rd_gnt low or when MAX_OUTST reads are in flight; responses are never stalled.
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   load_start, *_base_i, *_end_i   start pulse and byte range [base, end) of the bitstream
//   mem_rd_req/addr/gnt             external read request channel (word-aligned byte addresses)
//   mem_rd_valid/data               in-order read responses, big-endian byte order
//   BitStream_ram_ren/addr          decoder read port (ren active-low, 16-bit word address)
//   BitStream_buffer_input          registered 16-bit read data
//   load_busy/done/overflow         load status; overflow sticky until the next load_start
//   words_loaded                    count of valid 16-bit words written by the current load
module bitstream_ram_loader #(
  parameter int ADDR_W    = 17,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [31:0]       rf_rd_x0_buffer_req_base_i,
  input  logic [31:0]       rf_rd_x1_buffer_req_end_i,
  output logic              mem_rd_req,
  output logic [31:0]       mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  input  logic              BitStream_ram_ren,
  input  logic [ADDR_W-1:0] BitStream_ram_addr,
  output logic [15:0]       BitStream_buffer_input,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_overflow,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH   = 1 << (ADDR_W - 1);
  localparam int IDX_W   = ADDR_W - 1;
  localparam int OUTST_W = $clog2(MAX_OUTST + 1);

  localparam logic [29:0]         CAP_W30   = 30'(DEPTH);
  localparam logic [ADDR_W-1:0]   CAP_N     = ADDR_W'(DEPTH);
  localparam logic [OUTST_W-1:0]  OUTST_MAX = OUTST_W'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [29:0]        base_q, base_d;
  logic [ADDR_W-1:0]  nwords_q, nwords_d;
  logic [ADDR_W-1:0]  issued_q, issued_d;
  logic [ADDR_W-1:0]  received_q, received_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        rd_dat_q, rd_dat_d;

  logic [31:0]        ram [DEPTH];

  logic [29:0]        base_w, end_w, span_w;
  logic [ADDR_W-1:0]  len_nwords;
  logic               len_ovf;
  logic               busy, req, fire, rsp_acc;
  logic [31:0]        rd_entry;

  // Byte offsets inside a word carry no information for a word DMA.
  logic unused_lsbs;
  assign unused_lsbs = ^{rf_rd_x0_buffer_req_base_i[1:0], rf_rd_x1_buffer_req_end_i[1:0]};

  // Load length in 32-bit words, clamped to RAM capacity.
  always_comb begin
    base_w     = rf_rd_x0_buffer_req_base_i[31:2];
    end_w      = rf_rd_x1_buffer_req_end_i[31:2];
    span_w     = end_w - base_w;
    len_nwords = '0;
    len_ovf    = 1'b0;
    if (end_w > base_w) begin
      if (span_w > CAP_W30) begin
        len_nwords = CAP_N;
        len_ovf    = 1'b1;
      end else begin
        len_nwords = span_w[ADDR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    nwords_d   = nwords_q;
    issued_d   = issued_q;
    received_d = received_q;
    outst_d    = outst_q;
    ovf_d      = ovf_q;

    busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    req     = (state_q == S_ISSUE) && (issued_q < nwords_q) && (outst_q < OUTST_MAX);
    fire    = req && mem_rd_gnt;
    // Responses beyond the requested length cannot be legitimate; drop them.
    rsp_acc = mem_rd_valid && busy && (received_q < nwords_q);

    if (fire)    issued_d   = issued_q + ADDR_W'(1);
    if (rsp_acc) received_d = received_q + ADDR_W'(1);

    case ({fire, rsp_acc})
      2'b10:   outst_d = outst_q + OUTST_W'(1);
      2'b01:   outst_d = outst_q - OUTST_W'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          base_d     = base_w;
          nwords_d   = len_nwords;
          ovf_d      = len_ovf;
          issued_d   = '0;
          received_d = '0;
          outst_d    = '0;
          // A zero-length load also passes through ISSUE, which finishes it
          // immediately; this puts load_done two cycles after load_start.
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issued_q == nwords_q) begin
          // The last response may land in this very cycle; skip DRAIN then so
          // load_done always follows the final response by exactly one cycle.
          state_d = (received_d == nwords_q) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (received_d == nwords_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoder read port: old data on a same-entry read/write collision.
  always_comb begin
    rd_entry = ram[BitStream_ram_addr[ADDR_W-1:1]];
    rd_dat_d = rd_dat_q;
    if (!BitStream_ram_ren) begin
      rd_dat_d = BitStream_ram_addr[0] ? rd_entry[15:0] : rd_entry[31:16];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      nwords_q   <= '0;
      issued_q   <= '0;
      received_q <= '0;
      outst_q    <= '0;
      ovf_q      <= 1'b0;
      rd_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nwords_q   <= nwords_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      outst_q    <= outst_d;
      ovf_q      <= ovf_d;
      rd_dat_q   <= rd_dat_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rsp_acc) ram[received_q[IDX_W-1:0]] <= mem_rd_data;
  end

  assign mem_rd_req             = req;
  assign mem_rd_addr            = {base_q + 30'(issued_q), 2'b00};
  assign BitStream_buffer_input = rd_dat_q;
  assign load_busy              = busy;
  assign load_done              = (state_q == S_DONE);
  assign load_overflow          = ovf_q;
  assign words_loaded           = {received_q, 1'b0};

endmodule

// File: tb/tb_bitstream_ram_loader.sv
// Bench for bitstream_ram_loader: a full-size instance plus an ADDR_W=4 instance
// for the capacity-clamp case. A behavioural memory answers granted requests.
module tb_bitstream_ram_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        load_start, s_load_start;
  logic [31:0] base_i, end_i;
  logic        mem_rd_gnt;
  logic        mem_rd_valid, s_valid;
  logic [31:0] mem_rd_data;
  logic        ren, s_ren;
  logic [16:0] rd_addr;
  logic [3:0]  s_rd_addr;

  logic        req, s_req;
  logic [31:0] raddr, s_raddr;
  logic [15:0] rdata, s_rdata;
  logic        busy, s_busy, done, s_done, ovf, s_ovf;
  logic [17:0] wl;
  logic [4:0]  s_wl;

  bitstream_ram_loader #(.ADDR_W(17), .MAX_OUTST(4)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start),
    .rf_rd_x0_buffer_req_base_i(base_i), .rf_rd_x1_buffer_req_end_i(end_i),
    .mem_rd_req(req), .mem_rd_addr(raddr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .BitStream_ram_ren(ren), .BitStream_ram_addr(rd_addr), .BitStream_buffer_input(rdata),
    .load_busy(busy), .load_done(done), .load_overflow(ovf), .words_loaded(wl)
  );

  bitstream_ram_loader #(.ADDR_W(4), .MAX_OUTST(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .load_start(s_load_start),
    .rf_rd_x0_buffer_req_base_i(base_i), .rf_rd_x1_buffer_req_end_i(end_i),
    .mem_rd_req(s_req), .mem_rd_addr(s_raddr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(s_valid), .mem_rd_data(mem_rd_data),
    .BitStream_ram_ren(s_ren), .BitStream_ram_addr(s_rd_addr), .BitStream_buffer_input(s_rdata),
    .load_busy(s_busy), .load_done(s_done), .load_overflow(s_ovf), .words_loaded(s_wl)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          lat = 2;
  bit          rsp_en = 1'b0;
  bit          sel_small = 1'b0;
  bit          force_valid = 1'b0;
  int          rsp_count = 0;
  int          last_rsp_cyc = -1;
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] exp_addr_q[$];
  logic [15:0] exp_rd_q[$];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h0000_0001;
      32'h0000_1004: return 32'h6742_0029;
      32'h0000_1008: return 32'hAABB_CCDD;
      32'h0000_100C: return 32'h1122_3344;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  // One clock cycle: apply inputs just after the edge, run the memory model,
  // then observe the selected DUT at the falling edge.
  task automatic step(input bit start, input bit rd, input int ra,
                      output bit fired, output logic [31:0] faddr, output bit dn);
    logic [31:0] ra_v;
    ra_v = ra;
    @(posedge clk); #1;
    cyc++;
    load_start   = start & !sel_small;
    s_load_start = start & sel_small;
    ren          = sel_small ? 1'b1 : !rd;
    s_ren        = sel_small ? !rd : 1'b1;
    rd_addr      = ra_v[16:0];
    s_rd_addr    = ra_v[3:0];
    mem_rd_valid = 1'b0;
    s_valid      = 1'b0;
    if (force_valid) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'hDEAD_BEEF;
    end else if (rsp_en && pend_addr.size() > 0 && pend_cyc[0] + lat <= cyc) begin
      mem_rd_data = mem_model(pend_addr[0]);
      if (sel_small) s_valid = 1'b1; else mem_rd_valid = 1'b1;
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
      rsp_count++;
      last_rsp_cyc = cyc;
    end
    @(negedge clk);
    fired = sel_small ? (s_req & mem_rd_gnt) : (req & mem_rd_gnt);
    faddr = sel_small ? s_raddr : raddr;
    dn    = sel_small ? s_done : done;
    if (fired) begin
      pend_addr.push_back(faddr);
      pend_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_queues();
    pend_addr.delete(); pend_cyc.delete(); exp_addr_q.delete(); exp_rd_q.delete();
    rsp_count = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_start = 0; s_load_start = 0; base_i = 0; end_i = 0; mem_rd_gnt = 1;
    mem_rd_valid = 0; s_valid = 0; mem_rd_data = 0; ren = 1; s_ren = 1; rd_addr = 0; s_rd_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_tests++; if (req !== 1'b0)     begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
    n_tests++; if (raddr !== 32'h0)  begin n_fail++; $display("FAIL reset_addr: got %h want 0", raddr); end
    n_tests++; if (rdata !== 16'h0)  begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (ovf !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_tests++; if (wl !== 18'h0)     begin n_fail++; $display("FAIL reset_wl: got %0d want 0", wl); end
    n_tests++; if (s_req !== 1'b0 || s_wl !== 5'h0) begin n_fail++; $display("FAIL reset_small: req %b wl %0d want 0 0", s_req, s_wl); end
  endtask

  task automatic test_basic();
    bit f, d, rd_now, rd_chk;
    logic [31:0] fa, ea;
    logic [15:0] er;
    logic [15:0] tbl [6];
    int t0, first_f, last_f, nf, done_cnt, done_cyc;
    tbl = '{16'h0000, 16'h0001, 16'h6742, 16'h0029, 16'hAABB, 16'hCCDD};
    clear_queues();
    sel_small = 0; base_i = 32'h1000; end_i = 32'h1010; lat = 2; rsp_en = 1; mem_rd_gnt = 1;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h1000 + 32'(4 * i));
    step(1, 0, 0, f, fa, d); t0 = cyc;
    first_f = -1; last_f = -1; nf = 0; done_cnt = 0; done_cyc = -1; rd_now = 0; rd_chk = 0;
    for (int k = 0; k < 30; k++) begin
      step(0, rd_now, 7, f, fa, d);
      if (rd_chk) begin
        er = exp_rd_q.pop_front(); rd_chk = 0;
        n_tests++; if (rdata !== er) begin n_fail++; $display("FAIL basic_read_after_done: got %h want %h", rdata, er); end
      end
      if (rd_now) begin rd_now = 0; rd_chk = 1; end
      if (f) begin
        nf++; if (first_f < 0) first_f = cyc; last_f = cyc;
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL basic_extra_req: got addr %h want none", fa);
        end else begin
          ea = exp_addr_q.pop_front();
          n_tests++; if (fa !== ea) begin n_fail++; $display("FAIL basic_req_addr: got %h want %h", fa, ea); end
        end
      end
      if (d) begin done_cnt++; done_cyc = cyc; end
      if (rsp_count == 4 && last_rsp_cyc == cyc) begin rd_now = 1; exp_rd_q.push_back(16'h3344); end
    end
    n_tests++; if (nf != 4)             begin n_fail++; $display("FAIL basic_req_count: got %0d want 4", nf); end
    n_tests++; if (first_f != t0 + 1)   begin n_fail++; $display("FAIL basic_first_req: got cycle %0d want %0d", first_f, t0 + 1); end
    n_tests++; if (last_f != t0 + 4)    begin n_fail++; $display("FAIL basic_throughput: got last req cycle %0d want %0d", last_f, t0 + 4); end
    n_tests++; if (done_cnt != 1)       begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_tests++; if (done_cyc != last_rsp_cyc + 1) begin n_fail++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, last_rsp_cyc + 1); end
    n_tests++; if (wl !== 18'd8)        begin n_fail++; $display("FAIL basic_words_loaded: got %0d want 8", wl); end
    n_tests++; if (busy !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL basic_status: busy %b ovf %b want 0 0", busy, ovf); end
    for (int i = 0; i <= 6; i++) begin
      step(0, i < 6, i, f, fa, d);
      if (i > 0) begin
        er = exp_rd_q.pop_front();
        n_tests++; if (rdata !== er) begin n_fail++; $display("FAIL basic_read_%0d: got %h want %h", i - 1, rdata, er); end
      end
      if (i < 6) exp_rd_q.push_back(tbl[i]);
    end
  endtask

  task automatic test_empty();
    bit f, d, req_seen;
    logic [31:0] fa;
    int t0, done_cnt, done_cyc;
    clear_queues();
    sel_small = 0; base_i = 32'h2000; end_i = 32'h2000; rsp_en = 1; mem_rd_gnt = 1;
    step(1, 0, 0, f, fa, d); t0 = cyc;
    req_seen = 0; done_cnt = 0; done_cyc = -1;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, f, fa, d);
      if (req) req_seen = 1;
      if (d) begin done_cnt++; done_cyc = cyc; end
    end
    n_tests++; if (req_seen)          begin n_fail++; $display("FAIL empty_req: got req asserted want never"); end
    n_tests++; if (done_cyc != t0 + 2 || done_cnt != 1) begin n_fail++; $display("FAIL empty_done: got cycle %0d count %0d want %0d 1", done_cyc, done_cnt, t0 + 2); end
    n_tests++; if (wl !== 18'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL empty_status: wl %0d ovf %b want 0 0", wl, ovf); end
  endtask

  task automatic test_outstanding();
    bit f, d;
    logic [31:0] fa, ea;
    int nf, nf2, done_cnt;
    clear_queues();
    sel_small = 0; base_i = 32'h3000; end_i = 32'h3040; rsp_en = 0; mem_rd_gnt = 1;
    for (int i = 0; i < 16; i++) exp_addr_q.push_back(32'h3000 + 32'(4 * i));
    step(1, 0, 0, f, fa, d);
    nf = 0; nf2 = 0; done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, f, fa, d);
      if (f) begin
        nf++; ea = exp_addr_q.pop_front();
        n_tests++; if (fa !== ea) begin n_fail++; $display("FAIL outst_addr: got %h want %h", fa, ea); end
      end
    end
    n_tests++; if (nf != 4)      begin n_fail++; $display("FAIL outst_limit: got %0d accepted want 4", nf); end
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL outst_req_drop: got %b want 0", req); end
    rsp_en = 1; lat = 0;
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, f, fa, d);
      rsp_en = 0;
      if (f) begin
        nf2++; ea = exp_addr_q.pop_front();
        n_tests++; if (fa !== ea) begin n_fail++; $display("FAIL outst_addr: got %h want %h", fa, ea); end
      end
    end
    n_tests++; if (nf2 != 1) begin n_fail++; $display("FAIL outst_one_more: got %0d want 1", nf2); end
    rsp_en = 1; lat = 1;
    for (int k = 0; k < 100 && done_cnt == 0; k++) begin
      step(0, 0, 0, f, fa, d);
      if (f) begin
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL outst_extra_req: got addr %h want none", fa);
        end else begin
          ea = exp_addr_q.pop_front();
          n_tests++; if (fa !== ea) begin n_fail++; $display("FAIL outst_addr: got %h want %h", fa, ea); end
        end
      end
      if (d) done_cnt++;
    end
    n_tests++; if (exp_addr_q.size() != 0 || done_cnt != 1) begin n_fail++; $display("FAIL outst_complete: got %0d missing reqs, done %0d want 0 1", exp_addr_q.size(), done_cnt); end
    n_tests++; if (wl !== 18'd32) begin n_fail++; $display("FAIL outst_words_loaded: got %0d want 32", wl); end
  endtask

  task automatic test_overflow();
    bit f, d;
    logic [31:0] fa, ea, w;
    int nf, done_cnt;
    clear_queues();
    sel_small = 1; base_i = 32'h4000; end_i = 32'h4030; lat = 2; rsp_en = 1; mem_rd_gnt = 1;
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(32'h4000 + 32'(4 * i));
    step(1, 0, 0, f, fa, d);
    nf = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, f, fa, d);
      if (f) begin
        nf++;
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL ovf_extra_req: got addr %h want none", fa);
        end else begin
          ea = exp_addr_q.pop_front();
          n_tests++; if (fa !== ea) begin n_fail++; $display("FAIL ovf_addr: got %h want %h", fa, ea); end
        end
      end
      if (d) done_cnt++;
    end
    n_tests++; if (nf != 8)          begin n_fail++; $display("FAIL ovf_req_count: got %0d want 8", nf); end
    n_tests++; if (s_ovf !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: got %b want 1", s_ovf); end
    n_tests++; if (s_wl !== 5'd16)   begin n_fail++; $display("FAIL ovf_words_loaded: got %0d want 16", s_wl); end
    n_tests++; if (done_cnt != 1)    begin n_fail++; $display("FAIL ovf_done_count: got %0d want 1", done_cnt); end
    w = mem_model(32'h401C);
    step(0, 1, 15, f, fa, d);
    step(0, 0, 0, f, fa, d);
    n_tests++; if (s_rdata !== w[15:0]) begin n_fail++; $display("FAIL ovf_last_read: got %h want %h", s_rdata, w[15:0]); end
    sel_small = 0;
  endtask

  task automatic test_reset_mid();
    bit f, d;
    logic [31:0] fa, ea, w;
    int nf, done_cnt;
    clear_queues();
    sel_small = 0; base_i = 32'h5000; end_i = 32'h5020; lat = 2; rsp_en = 1; mem_rd_gnt = 1;
    step(1, 0, 0, f, fa, d);
    for (int k = 0; k < 30 && rsp_count < 2; k++) step(0, 0, 0, f, fa, d);
    n_tests++; if (rsp_count != 2) begin n_fail++; $display("FAIL rmid_progress: got %0d responses want 2", rsp_count); end
    rsp_en = 0;
    step(0, 0, 0, f, fa, d);
    reset_n = 1'b0; #1;
    n_tests++; if (req !== 1'b0 || raddr !== 32'h0) begin n_fail++; $display("FAIL rmid_req: req %b addr %h want 0 0", req, raddr); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_status: busy %b done %b ovf %b want 0 0 0", busy, done, ovf); end
    n_tests++; if (wl !== 18'd0 || rdata !== 16'h0) begin n_fail++; $display("FAIL rmid_wl_rdata: wl %0d rdata %h want 0 0", wl, rdata); end
    clear_queues();
    step(0, 0, 0, f, fa, d);
    reset_n = 1'b1;
    force_valid = 1;
    step(0, 0, 0, f, fa, d);
    force_valid = 0;
    step(0, 0, 0, f, fa, d);
    n_tests++; if (wl !== 18'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_late_valid: wl %0d busy %b want 0 0", wl, busy); end
    w = mem_model(32'h5000);
    step(0, 1, 0, f, fa, d);
    step(0, 1, 1, f, fa, d);
    n_tests++; if (rdata !== w[31:16]) begin n_fail++; $display("FAIL rmid_ram_hi: got %h want %h", rdata, w[31:16]); end
    step(0, 0, 0, f, fa, d);
    n_tests++; if (rdata !== w[15:0]) begin n_fail++; $display("FAIL rmid_ram_lo: got %h want %h", rdata, w[15:0]); end
    base_i = 32'h6000; end_i = 32'h6010; lat = 1; rsp_en = 1;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h6000 + 32'(4 * i));
    step(1, 0, 0, f, fa, d);
    nf = 0; done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, f, fa, d);
      if (f) begin
        nf++;
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL reload_extra_req: got addr %h want none", fa);
        end else begin
          ea = exp_addr_q.pop_front();
          n_tests++; if (fa !== ea) begin n_fail++; $display("FAIL reload_addr: got %h want %h", fa, ea); end
        end
      end
      if (d) done_cnt++;
    end
    n_tests++; if (nf != 4 || done_cnt != 1 || wl !== 18'd8) begin n_fail++; $display("FAIL reload_complete: reqs %0d done %0d wl %0d want 4 1 8", nf, done_cnt, wl); end
    w = mem_model(32'h600C);
    step(0, 1, 6, f, fa, d);
    step(0, 0, 0, f, fa, d);
    n_tests++; if (rdata !== w[31:16]) begin n_fail++; $display("FAIL reload_read: got %h want %h", rdata, w[31:16]); end
  endtask

  task automatic test_hold_and_busy();
    bit f, d;
    logic [31:0] fa, ea, w;
    int nf, done_cnt;
    clear_queues();
    sel_small = 0;
    w = mem_model(32'h6004);
    step(0, 1, 2, f, fa, d);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 5 + k, f, fa, d);
      n_tests++; if (rdata !== w[31:16]) begin n_fail++; $display("FAIL hold_read_%0d: got %h want %h", k, rdata, w[31:16]); end
    end
    base_i = 32'h7000; end_i = 32'h7020; rsp_en = 0; mem_rd_gnt = 1; lat = 1;
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(32'h7000 + 32'(4 * i));
    nf = 0; done_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == 3) begin base_i = 32'h9000; end_i = 32'h9100; end
      if (k == 4) rsp_en = 1;
      step(k == 0 || k == 3, 0, 0, f, fa, d);
      if (f) begin
        nf++;
        if (exp_addr_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL busy_extra_req: got addr %h want none", fa);
        end else begin
          ea = exp_addr_q.pop_front();
          n_tests++; if (fa !== ea) begin n_fail++; $display("FAIL busy_addr: got %h want %h", fa, ea); end
        end
      end
      if (d) done_cnt++;
    end
    n_tests++; if (nf != 8 || done_cnt != 1) begin n_fail++; $display("FAIL busy_ignore: reqs %0d done %0d want 8 1", nf, done_cnt); end
    n_tests++; if (wl !== 18'd16) begin n_fail++; $display("FAIL busy_words_loaded: got %0d want 16", wl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_outstanding();
    test_overflow();
    test_reset_mid();
    test_hold_and_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
